// File: rtl/dram_byte_responder.sv
// Byte-wide DRAM model behind the MDR byte port: one read or write at a time,
// request/done handshake, programmable read latency (READ_LAT edges from accept).
module dram_byte_responder #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        DRAM_in,
  output logic [7:0]        DRAM_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RD_WAIT   = 2'd1,
    ST_WR_COMMIT = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [7:0]          data_r, data_s;
  logic [7:0]          dout_r;
  logic                busy_r, done_r, err_r;
  logic                done_s, err_s, rd_fire_s, mem_we_s;
  logic [7:0]          mem_r [0:DEPTH-1];

  // Next-state, request decode and completion strobes
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    data_s    = data_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    rd_fire_s = 1'b0;
    mem_we_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (read_en && write_en) begin
          err_s = 1'b1;
        end else if (read_en) begin
          addr_s  = addr;
          cnt_s   = LAT_M1;
          state_s = ST_RD_WAIT;
        end else if (write_en) begin
          addr_s  = addr;
          data_s  = DRAM_in;
          state_s = ST_WR_COMMIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_r == 4'd0) begin
          rd_fire_s = 1'b1;
          done_s    = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_WR_COMMIT: begin
        mem_we_s = 1'b1;
        done_s   = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      data_r  <= 8'd0;
      dout_r  <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= done_s;
      err_r   <= err_s;
      if (rd_fire_s) begin
        dout_r <= mem_r[addr_r];
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  // Storage array has no reset so it maps onto RAM; contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[addr_r] <= data_r;
    end
  end

  assign DRAM_out = dout_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_dram_byte_responder.sv
// Directed bench for dram_byte_responder: three instances (READ_LAT 2, 1, 4),
// a byte model per instance and a scoreboard queue of expected read data.
module tb_dram_byte_responder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_en;
  logic [2:0]  wr_en;
  logic [11:0] addr_v [3];
  logic [7:0]  din_v  [3];
  wire  [7:0]  dout_v [3];
  wire  [2:0]  busy_v;
  wire  [2:0]  done_v;
  wire  [2:0]  err_v;

  int          total;
  int          bad;
  int          lat_tab [3];
  logic [7:0]  model [3][4096];
  logic [7:0]  sb_q [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dram_byte_responder #(
      .ADDR_W   (12),
      .READ_LAT ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .read_en  (rd_en[g]),
      .write_en (wr_en[g]),
      .addr     (addr_v[g]),
      .DRAM_in  (din_v[g]),
      .DRAM_out (dout_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .err      (err_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the completion edge.
  task automatic do_write(input int k, input logic [11:0] a, input logic [7:0] d);
    logic [7:0] prev;
    prev      = dout_v[k];
    wr_en[k]  = 1'b1;
    addr_v[k] = a;
    din_v[k]  = d;
    @(posedge clk); @(negedge clk);
    wr_en[k] = 1'b0;
    check("wr_busy", busy_v[k], 1);
    check("wr_done_early", done_v[k], 0);
    @(posedge clk); @(negedge clk);
    check("wr_done", done_v[k], 1);
    check("wr_busy_fall", busy_v[k], 0);
    check("wr_dout_hold", dout_v[k], prev);
    model[k][a] = d;
  endtask

  // poke re-raises read_en for one cycle while the read is in flight.
  task automatic do_read(input int k, input logic [11:0] a, input bit poke);
    bit         seen;
    logic [7:0] exp_b;
    rd_en[k]  = 1'b1;
    addr_v[k] = a;
    sb_q.push_back(model[k][a]);
    @(posedge clk); @(negedge clk);
    check("rd_busy", busy_v[k], 1);
    rd_en[k] = poke;
    seen  = 1'b0;
    exp_b = 8'd0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); @(negedge clk);
      rd_en[k] = 1'b0;
      if (done_v[k]) begin
        seen  = 1'b1;
        exp_b = sb_q.pop_front();
        check("rd_latency", n, lat_tab[k]);
        check("rd_data", dout_v[k], exp_b);
        check("rd_busy_fall", busy_v[k], 0);
        check("rd_no_err", err_v[k], 0);
      end
    end
    if (!seen) begin
      void'(sb_q.pop_front());
      check("rd_timeout", 0, 1);
    end else begin
      @(posedge clk); @(negedge clk);
      check("rd_done_single", done_v[k], 0);
      check("rd_dout_hold", dout_v[k], exp_b);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    lat_tab[0] = 2; lat_tab[1] = 1; lat_tab[2] = 4;
    rst_n = 1'b0;
    rd_en = 3'b000;
    wr_en = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 12'h000;
      din_v[i]  = 8'h00;
    end

    // power-on reset values
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("por_dout", dout_v[i], 0);
      check("por_busy", busy_v[i], 0);
      check("por_done", done_v[i], 0);
      check("por_err", err_v[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // write then read, READ_LAT=2
    do_write(0, 12'h010, 8'd150);
    do_read(0, 12'h010, 1'b0);
    check("wr_rd_value", dout_v[0], 8'h96);

    // overwrite, then read with a request poked during busy
    do_write(0, 12'h010, 8'hFF);
    do_read(0, 12'h010, 1'b1);
    check("overwrite_value", dout_v[0], 8'hFF);

    // simultaneous request is rejected
    do_write(0, 12'h020, 8'h33);
    rd_en[0] = 1'b1; wr_en[0] = 1'b1; addr_v[0] = 12'h020; din_v[0] = 8'hA5;
    @(posedge clk); @(negedge clk);
    rd_en[0] = 1'b0; wr_en[0] = 1'b0;
    check("both_err", err_v[0], 1);
    check("both_busy", busy_v[0], 0);
    check("both_done", done_v[0], 0);
    @(posedge clk); @(negedge clk);
    check("both_err_pulse", err_v[0], 0);
    check("both_busy_after", busy_v[0], 0);
    do_read(0, 12'h020, 1'b0);
    check("both_no_write", dout_v[0], 8'h33);

    // asynchronous reset one cycle into a read
    rd_en[0] = 1'b1; addr_v[0] = 12'h010;
    @(posedge clk); @(negedge clk);
    rd_en[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_dout", dout_v[0], 0);
    check("rst_async_busy", busy_v[0], 0);
    check("rst_async_done", done_v[0], 0);
    check("rst_async_err", err_v[0], 0);
    @(posedge clk); @(negedge clk);
    check("rst_rd_no_done", done_v[0], 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_rd_no_done_after", done_v[0], 0);
    check("rst_rd_dout_after", dout_v[0], 0);

    // reset between write accept and commit drops the write
    wr_en[0] = 1'b1; addr_v[0] = 12'h010; din_v[0] = 8'h77;
    @(posedge clk);
    #2 rst_n = 1'b0;
    wr_en[0] = 1'b0;
    #1;
    check("rst_wr_busy", busy_v[0], 0);
    @(posedge clk); @(negedge clk);
    check("rst_wr_no_done", done_v[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(0, 12'h010, 1'b0);
    check("rst_wr_kept", dout_v[0], 8'hFF);

    // address wrap and latency sweep across all instances
    for (int k = 0; k < 3; k++) begin
      do_write(k, 12'hFFF, 8'h5A);
      do_write(k, 12'h000, 8'h3C);
      do_read(k, 12'hFFF, 1'b0);
      check("wrap_hi", dout_v[k], 8'h5A);
      do_read(k, 12'h000, 1'b0);
      check("wrap_lo", dout_v[k], 8'h3C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_byte_responder.md
# dram_byte_responder

DRAM-side responder for the memory data register's byte interface in the image-convolution processor. It holds the byte-wide image/data memory and serves one read or write request at a time from the MDR, using a request/done handshake with a programmable read latency. Its `DRAM_out` drives the MDR's `DRAM_in`, and its `DRAM_in` is driven by the MDR's `DRAM_out`.

## Interface
- `ADDR_W`, default 12: byte address width; memory depth is 2**ADDR_W bytes, fully decoded.
- `READ_LAT`, default 2: cycles from read accept edge to read data valid; legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `read_en`  in  1  read request, sampled only while idle.
- `write_en`  in  1  write request, sampled only while idle.
- `addr`  in  ADDR_W  byte address, sampled at the accept edge.
- `DRAM_in`  in  8  write data from the MDR, sampled at the accept edge.
- `DRAM_out`  out  8  read data to the MDR; holds the last completed read.
- `busy`  out  1  high while a request is in flight (state != IDLE).
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse on a rejected simultaneous read and write request.

## Operation
- States: IDLE, RD_WAIT, WR_COMMIT.
- **Reset** (`rst_n` low, any time): state goes to IDLE, and `DRAM_out`, `busy`, `done`, `err` and the latency counter go to 0. Memory contents are not cleared.
- **IDLE, `read_en`=1, `write_en`=0:** latch `addr`, load the counter with READ_LAT-1, go to RD_WAIT.
- **IDLE, `write_en`=1, `read_en`=0:** latch `addr` and `DRAM_in`, go to WR_COMMIT.
- **IDLE, both high:** no transaction; `err`=1 for one cycle; stay in IDLE.
- **RD_WAIT:**
  - Counter > 0: decrement.
  - Counter == 0: `DRAM_out` <= mem[addr_q], `done`=1 for one cycle, go to IDLE.
- **WR_COMMIT:** mem[addr_q] <= data_q, `done`=1 for one cycle, go to IDLE. `DRAM_out` is unchanged.
- **Requests outside IDLE:** ignored. There is no queue and no `err`. The MDR must wait for `done`.
- **Address range:** addresses wrap implicitly at 2**ADDR_W. There is no out-of-range case.
- **Read after write:** a read of an address just written returns the new byte.
- **Uninitialized locations:** reads return X in simulation. The bench must write before reading.

## Timing
- Accept edge T0 is the rising edge with state IDLE and exactly one request high. `busy` is 1 from T0 through the completion edge.
- **Read:**
  - `DRAM_out` and `done` update at edge T0+READ_LAT.
  - `busy` falls at that same edge.
  - The next request can be accepted at T0+READ_LAT+1.
- **Write:**
  - Memory commits at T0+1; `done` goes high at T0+1.
  - The next request can be accepted at T0+2.
- **Pulse widths:** `done` and `err` are exactly one cycle each and never high together.
- **Held request:** a request still high after `done` is re-accepted at the next edge. This is the MDR's responsibility and is not an error.
- **Reset mid-read:** no `done` pulse, and `DRAM_out` goes to 0.
- **Reset mid-write (between T0 and T0+1):** the write is dropped and memory is unchanged.
- **Back-to-back throughput:** one read per READ_LAT+1 cycles; one write per 2 cycles.

## Test plan
- **Reset values:** assert `rst_n`=0 asynchronously mid-cycle → `DRAM_out`=00, `busy`=0, `done`=0, `err`=0 immediately, without waiting for a clock edge.
- **Write then read:** write 8'd150 to addr 12'h010, then read 12'h010 with READ_LAT=2:
  - `done` at T0+1 for the write;
  - `done` at T0'+2 for the read;
  - `DRAM_out`=8'h96 from that edge on.
- **Overwrite and hold:** write 8'hFF to 12'h010, read it → `DRAM_out`=FF. Then pulse `read_en` during the busy cycle → no extra `done`, and `DRAM_out` stays FF until the next completed read.
- **Simultaneous request:** `read_en`=`write_en`=1 in IDLE with `DRAM_in`=8'hA5, `addr`=12'h020 → `err` pulses one cycle, `busy` stays 0, and a later read of 12'h020 returns the prior byte, not A5.
- **Reset mid-transaction:**
  - `rst_n` low one cycle after a read accept → no `done`, `DRAM_out`=00.
  - `rst_n` low between a write accept and T0+1 → the location keeps its old value.
- **Address wrap and latency sweep:** write 8'h5A to 12'hFFF and 8'h3C to 12'h000, read both → 5A and 3C returned. Repeat with READ_LAT=1 and READ_LAT=4, checking `done` lands exactly at T0+READ_LAT.
